// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: instruction fetch vs. load/store with round-robin fairness,
// one outstanding access at a time. Define ARBITER_DEBUG_PORT_EN to add a top-priority dbg_* port.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
`ifdef ARBITER_DEBUG_PORT_EN
    input  logic                    dbg_req,
    input  logic                    dbg_we,
    input  logic [DATA_WIDTH/8-1:0] dbg_be,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    output logic                    dbg_gnt,
    output logic                    dbg_rvalid,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,
`endif
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-3:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

`ifdef ARBITER_DEBUG_PORT_EN
    localparam int NREQ = 3;
`else
    localparam int NREQ = 2;
`endif
    localparam int BE_W  = DATA_WIDTH/8;
    localparam int WA_W  = ADDR_WIDTH-2;
    localparam int SEL_W = $clog2(NREQ);
    localparam int LAT_W = $clog2(RD_LATENCY+1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [SEL_W-1:0] SEL_IF   = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_D    = SEL_W'(1);
`ifdef ARBITER_DEBUG_PORT_EN
    localparam logic [SEL_W-1:0] SEL_DBG  = SEL_W'(2);
`endif

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t           state_reg, state_next;
    logic [LAT_W-1:0] lat_cnt_reg, lat_cnt_next;
    logic [SEL_W-1:0] owner_reg, owner_next;
    logic             owner_we_reg, owner_we_next;
    logic             rr_prefer_data_reg, rr_prefer_data_next;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             rsp_fire;

    logic [NREQ-1:0]                 req_vec, we_vec, gnt_vec, rvalid_vec;
    logic [NREQ-1:0][BE_W-1:0]       be_vec;
    logic [NREQ-1:0][WA_W-1:0]       waddr_vec;
    logic [NREQ-1:0][DATA_WIDTH-1:0] wdata_vec, rdata_vec;
    logic                            addr_lsb_unused;

    // Fetches are always full-word reads.
    assign req_vec[SEL_IF]   = if_req;
    assign we_vec[SEL_IF]    = 1'b0;
    assign be_vec[SEL_IF]    = '1;
    assign waddr_vec[SEL_IF] = if_addr[ADDR_WIDTH-1:2];
    assign wdata_vec[SEL_IF] = '0;
    assign if_gnt            = gnt_vec[SEL_IF];
    assign if_rvalid         = rvalid_vec[SEL_IF];
    assign if_rdata          = rdata_vec[SEL_IF];

    assign req_vec[SEL_D]    = d_req;
    assign we_vec[SEL_D]     = d_we;
    assign be_vec[SEL_D]     = d_be;
    assign waddr_vec[SEL_D]  = d_addr[ADDR_WIDTH-1:2];
    assign wdata_vec[SEL_D]  = d_wdata;
    assign d_gnt             = gnt_vec[SEL_D];
    assign d_rvalid          = rvalid_vec[SEL_D];
    assign d_rdata           = rdata_vec[SEL_D];

`ifdef ARBITER_DEBUG_PORT_EN
    assign req_vec[SEL_DBG]   = dbg_req;
    assign we_vec[SEL_DBG]    = dbg_we;
    assign be_vec[SEL_DBG]    = dbg_be;
    assign waddr_vec[SEL_DBG] = dbg_addr[ADDR_WIDTH-1:2];
    assign wdata_vec[SEL_DBG] = dbg_wdata;
    assign dbg_gnt            = gnt_vec[SEL_DBG];
    assign dbg_rvalid         = rvalid_vec[SEL_DBG];
    assign dbg_rdata          = rdata_vec[SEL_DBG];
    assign addr_lsb_unused    = ^{if_addr[1:0], d_addr[1:0], dbg_addr[1:0]};
`else
    assign addr_lsb_unused    = ^{if_addr[1:0], d_addr[1:0]};
`endif

    assign rsp_fire = (state_reg == ST_WAIT) && (lat_cnt_reg == LAT_LAST);

    always_comb begin
        sel       = SEL_IF;
        sel_valid = 1'b0;
`ifdef ARBITER_DEBUG_PORT_EN
        if (req_vec[SEL_DBG]) begin
            sel       = SEL_DBG;
            sel_valid = 1'b1;
        end else
`endif
        if (req_vec[SEL_IF] && req_vec[SEL_D]) begin
            sel       = rr_prefer_data_reg ? SEL_D : SEL_IF;
            sel_valid = 1'b1;
        end else if (req_vec[SEL_IF]) begin
            sel       = SEL_IF;
            sel_valid = 1'b1;
        end else if (req_vec[SEL_D]) begin
            sel       = SEL_D;
            sel_valid = 1'b1;
        end
    end

    always_comb begin
        state_next          = state_reg;
        lat_cnt_next        = lat_cnt_reg;
        owner_next          = owner_reg;
        owner_we_next       = owner_we_reg;
        rr_prefer_data_next = rr_prefer_data_reg;
        gnt_vec             = '0;
        mem_en              = 1'b0;
        mem_we              = 1'b0;
        mem_be              = '0;
        mem_addr            = '0;
        mem_wdata           = '0;
        case (state_reg)
            ST_IDLE: begin
                // Grants are held off while reset is asserted so every output reads zero.
                if (sel_valid && reset) begin
                    gnt_vec[sel]  = 1'b1;
                    mem_en        = 1'b1;
                    mem_we        = we_vec[sel];
                    mem_be        = be_vec[sel];
                    mem_addr      = waddr_vec[sel];
                    mem_wdata     = wdata_vec[sel];
                    owner_next    = sel;
                    owner_we_next = we_vec[sel];
                    lat_cnt_next  = LAT_ONE;
                    state_next    = ST_WAIT;
                    if (sel == SEL_IF) begin
                        rr_prefer_data_next = 1'b1;
                    end else if (sel == SEL_D) begin
                        rr_prefer_data_next = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (rsp_fire) begin
                    lat_cnt_next = '0;
                    state_next   = ST_IDLE;
                end else begin
                    lat_cnt_next = lat_cnt_reg + LAT_ONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg          <= ST_IDLE;
            lat_cnt_reg        <= '0;
            owner_reg          <= SEL_IF;
            owner_we_reg       <= 1'b0;
            rr_prefer_data_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            lat_cnt_reg        <= lat_cnt_next;
            owner_reg          <= owner_next;
            owner_we_reg       <= owner_we_next;
            rr_prefer_data_reg <= rr_prefer_data_next;
        end
    end

    // Read data is forwarded in the rvalid cycle and then held in the owner's register.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
        logic [DATA_WIDTH-1:0] rdata_reg;
        logic                  load;

        assign rvalid_vec[gi] = rsp_fire && (owner_reg == SEL_W'(gi));
        assign load           = rvalid_vec[gi] && !owner_we_reg;
        assign rdata_vec[gi]  = load ? mem_rdata : rdata_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rdata_reg <= '0;
            end else if (load) begin
                rdata_reg <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (RD_LATENCY 1..3) sharing a memory model.
// Define ARBITER_DEBUG_PORT_EN to also exercise the debug-port priority sequence.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    logic        if_req [3], if_gnt [3], if_rvalid [3];
    logic [31:0] if_addr [3], if_rdata [3];
    logic        d_req [3], d_we [3], d_gnt [3], d_rvalid [3];
    logic [3:0]  d_be [3];
    logic [31:0] d_addr [3], d_wdata [3], d_rdata [3];
`ifdef ARBITER_DEBUG_PORT_EN
    logic        dbg_req [3], dbg_we [3], dbg_gnt [3], dbg_rvalid [3];
    logic [3:0]  dbg_be [3];
    logic [31:0] dbg_addr [3], dbg_wdata [3], dbg_rdata [3];
`endif
    logic        mem_en [3], mem_we [3];
    logic [3:0]  mem_be [3];
    logic [29:0] mem_addr [3];
    logic [31:0] mem_wdata [3], mem_rdata [3];

    logic [31:0] mem [64];
    logic [31:0] rd_pipe [3][3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_WIDTH(32),
            .DATA_WIDTH(32),
            .RD_LATENCY(gi + 1)
        ) u_dut (
            .clk       (clk),
            .reset     (rst_n),
            .if_req    (if_req[gi]),
            .if_addr   (if_addr[gi]),
            .if_gnt    (if_gnt[gi]),
            .if_rvalid (if_rvalid[gi]),
            .if_rdata  (if_rdata[gi]),
            .d_req     (d_req[gi]),
            .d_we      (d_we[gi]),
            .d_be      (d_be[gi]),
            .d_addr    (d_addr[gi]),
            .d_wdata   (d_wdata[gi]),
            .d_gnt     (d_gnt[gi]),
            .d_rvalid  (d_rvalid[gi]),
            .d_rdata   (d_rdata[gi]),
`ifdef ARBITER_DEBUG_PORT_EN
            .dbg_req   (dbg_req[gi]),
            .dbg_we    (dbg_we[gi]),
            .dbg_be    (dbg_be[gi]),
            .dbg_addr  (dbg_addr[gi]),
            .dbg_wdata (dbg_wdata[gi]),
            .dbg_gnt   (dbg_gnt[gi]),
            .dbg_rvalid(dbg_rvalid[gi]),
            .dbg_rdata (dbg_rdata[gi]),
`endif
            .mem_en    (mem_en[gi]),
            .mem_we    (mem_we[gi]),
            .mem_be    (mem_be[gi]),
            .mem_addr  (mem_addr[gi]),
            .mem_wdata (mem_wdata[gi]),
            .mem_rdata (mem_rdata[gi])
        );
        // Instance gi sees read data gi+1 cycles after its strobe.
        assign mem_rdata[gi] = rd_pipe[gi][gi];
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            mem[4]  <= 32'h0050_0093;
            mem[16] <= 32'hCAFE_0040;
            mem[32] <= 32'h1122_3344;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (mem_en[k] && mem_we[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[k][b]) mem[mem_addr[k][5:0]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
                    end
                end
                rd_pipe[k][0] <= mem[mem_addr[k][5:0]];
                rd_pipe[k][1] <= rd_pipe[k][0];
                rd_pipe[k][2] <= rd_pipe[k][1];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Data-port access on the latency-1 instance; entered and left 1ns after a rising edge in IDLE.
    task automatic d_access(input string tag, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd);
        d_req[0] = 1'b1; d_we[0] = we; d_be[0] = be; d_addr[0] = addr; d_wdata[0] = wd;
        @(negedge clk);
        check({tag, "_gnt"}, d_gnt[0], 1'b1);
        check({tag, "_mem_we"}, mem_we[0], we);
        check({tag, "_mem_be"}, mem_be[0], we ? be : 4'hF & be);
        check({tag, "_mem_addr"}, mem_addr[0], addr[31:2]);
        if (we) check({tag, "_mem_wdata"}, mem_wdata[0], wd);
        @(posedge clk); #1;
        d_req[0] = 1'b0;
        @(negedge clk);
        check({tag, "_rvalid"}, d_rvalid[0], 1'b1);
        check({tag, "_rdata"}, d_rdata[0], exp_rd);
        $display("txn d we=%0d be=%h addr=%h wdata=%h rdata=%h", we, be, addr, wd, d_rdata[0]);
        @(posedge clk); #1;
    endtask

    // Fetch from 0x10 held across WAIT: no grant until N+L+1, rvalid exactly at N+L.
    task automatic fetch_sweep(input int k);
        int lat;
        lat = k + 1;
        if_req[k] = 1'b1; if_addr[k] = 32'h10;
        @(negedge clk);
        check($sformatf("L%0d_gnt", lat), if_gnt[k], 1'b1);
        check($sformatf("L%0d_mem_en", lat), mem_en[k], 1'b1);
        check($sformatf("L%0d_mem_addr", lat), mem_addr[k], 30'd4);
        check($sformatf("L%0d_mem_be", lat), mem_be[k], 4'hF);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check($sformatf("L%0d_c%0d_nogrant", lat, c), if_gnt[k], 1'b0);
            check($sformatf("L%0d_c%0d_mem_en", lat, c), mem_en[k], 1'b0);
            check($sformatf("L%0d_c%0d_rvalid", lat, c), if_rvalid[k], c == lat);
            if (c == lat) check($sformatf("L%0d_rdata", lat), if_rdata[k], 32'h0050_0093);
        end
        @(negedge clk);
        check($sformatf("L%0d_regrant", lat), if_gnt[k], 1'b1);
        $display("txn if lat=%0d addr=%h rdata=%h", lat, if_addr[k], if_rdata[k]);
        @(posedge clk); #1;
        if_req[k] = 1'b0;
        repeat (lat) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_be[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
`ifdef ARBITER_DEBUG_PORT_EN
            dbg_req[k] = 1'b0; dbg_we[k] = 1'b0; dbg_be[k] = '0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
`endif
        end
        // Contention requests are held from before reset release.
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        d_req[0] = 1'b1; d_addr[0] = 32'h40;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_if_gnt", if_gnt[0], 1'b0);
        check("rst_d_gnt", d_gnt[0], 1'b0);
        check("rst_mem_en", mem_en[0], 1'b0);
        check("rst_mem_be", mem_be[0], 4'h0);
        check("rst_mem_addr", mem_addr[0], 30'd0);
        check("rst_if_rvalid", if_rvalid[0], 1'b0);
        check("rst_if_rdata", if_rdata[0], 32'h0);
        check("rst_d_rdata", d_rdata[0], 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Both held: grants if,d,if,d every second cycle, responses in between.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("cont_%0d_if_gnt", i), if_gnt[0], (i % 4) == 0);
            check($sformatf("cont_%0d_d_gnt", i), d_gnt[0], (i % 4) == 2);
            check($sformatf("cont_%0d_if_rvalid", i), if_rvalid[0], (i % 4) == 1);
            check($sformatf("cont_%0d_d_rvalid", i), d_rvalid[0], (i % 4) == 3);
            if ((i % 4) == 0) check($sformatf("cont_%0d_addr", i), mem_addr[0], 30'd4);
            if ((i % 4) == 2) check($sformatf("cont_%0d_addr", i), mem_addr[0], 30'd16);
            if ((i % 4) == 1) check($sformatf("cont_%0d_if_rdata", i), if_rdata[0], 32'h0050_0093);
            if ((i % 4) == 3) check($sformatf("cont_%0d_d_rdata", i), d_rdata[0], 32'hCAFE_0040);
            if ((i % 2) == 0) $display("txn contention cycle=%0d if_gnt=%0d d_gnt=%0d", i, if_gnt[0], d_gnt[0]);
        end
        @(posedge clk); #1;
        if_req[0] = 1'b0; d_req[0] = 1'b0;

        d_access("wr_be3", 1'b1, 4'b0011, 32'h80, 32'hAABB_CCDD, 32'hCAFE_0040);
        d_access("rd_after_wr", 1'b0, 4'b0000, 32'h80, 32'h0, 32'h1122_CCDD);
        d_access("wr_be0", 1'b1, 4'b0000, 32'h80, 32'hFFFF_FFFF, 32'h1122_CCDD);
        d_access("rd_after_be0", 1'b0, 4'b0000, 32'h80, 32'h0, 32'h1122_CCDD);

        fetch_sweep(0);
        fetch_sweep(1);
        fetch_sweep(2);

        // Reset one cycle after a data grant on the latency-3 instance.
        d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h40;
        @(negedge clk);
        check("rstmid_d_gnt", d_gnt[2], 1'b1);
        @(posedge clk); #1;
        d_req[2] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_d_gnt_low", d_gnt[2], 1'b0);
        check("rstmid_d_rvalid", d_rvalid[2], 1'b0);
        check("rstmid_mem_en", mem_en[2], 1'b0);
        check("rstmid_if_rdata", if_rdata[2], 32'h0);
        check("rstmid_d_rdata", d_rdata[2], 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("rstmid_post_%0d_d_rvalid", i), d_rvalid[2], 1'b0);
            check($sformatf("rstmid_post_%0d_if_rvalid", i), if_rvalid[2], 1'b0);
        end
        @(posedge clk); #1;
        fetch_sweep(2);

`ifdef ARBITER_DEBUG_PORT_EN
        // Round-robin pointer is at its reset value here: expect dbg, if, d.
        dbg_req[0] = 1'b1; dbg_we[0] = 1'b0; dbg_addr[0] = 32'h40;
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h80;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("dbg_%0d_dbg_gnt", i), dbg_gnt[0], i == 0);
            check($sformatf("dbg_%0d_if_gnt", i), if_gnt[0], i == 2);
            check($sformatf("dbg_%0d_d_gnt", i), d_gnt[0], i == 4);
            check($sformatf("dbg_%0d_dbg_rvalid", i), dbg_rvalid[0], i == 1);
            check($sformatf("dbg_%0d_if_rvalid", i), if_rvalid[0], i == 3);
            check($sformatf("dbg_%0d_d_rvalid", i), d_rvalid[0], i == 5);
            if (i == 1) check("dbg_rdata", dbg_rdata[0], 32'hCAFE_0040);
            if (i == 3) check("dbg_if_rdata", if_rdata[0], 32'h0050_0093);
            if (i == 5) check("dbg_d_rdata", d_rdata[0], 32'h1122_3344);
            if ((i % 2) == 0) $display("txn priority cycle=%0d dbg=%0d if=%0d d=%0d", i, dbg_gnt[0], if_gnt[0], d_gnt[0]);
            @(posedge clk); #1;
            if (i == 0) dbg_req[0] = 1'b0;
            if (i == 2) if_req[0] = 1'b0;
            if (i == 4) d_req[0] = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
